// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_ctrl
// Purpose : arbitrates data/fetch ports onto a byte-wide RAM/IO bus,
//           serialising little-endian 1/2/4-byte transfers.
// Rev     : 1.0  initial release
// ============================================================================
module ram_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              en_i,
  input  logic              rw_i,
  input  logic [2:0]        width_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              rdy_o,
  output logic [31:0]       data_o,
  input  logic              if_en_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_rdy_o,
  output logic [31:0]       if_data_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_read  = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_width;
  logic              r_port_if;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_rdy;
  logic              r_if_rdy;
  logic [31:0]       r_data;
  logic [31:0]       r_if_data;

  logic              w_take;
  logic [ADDR_W-1:0] w_req_addr;
  logic [2:0]        w_req_width;
  logic              w_req_stall;
  logic [ADDR_W-1:0] w_byte_addr;
  logic              w_byte_stall;
  logic [7:0]        w_wr_byte;
  logic [1:0]        w_rd_idx;
  logic [31:0]       w_assembled;

  always_comb begin
    w_take      = en_i | if_en_i;
    w_req_addr  = en_i ? addr_i : if_addr_i;
    case (width_i)
      3'd1:    w_req_width = 3'd1;
      3'd2:    w_req_width = 3'd2;
      default: w_req_width = 3'd4;
    endcase
    if (!en_i) begin
      w_req_width = 3'd4;
    end
    w_req_stall  = (w_req_addr[17:16] == IO_SEL) && io_buffer_full;
    w_byte_addr  = r_addr + ADDR_W'(r_cnt);
    w_byte_stall = (w_byte_addr[17:16] == IO_SEL) && io_buffer_full;
    case (r_cnt[1:0])
      2'd0:    w_wr_byte = r_wdata[7:0];
      2'd1:    w_wr_byte = r_wdata[15:8];
      2'd2:    w_wr_byte = r_wdata[23:16];
      default: w_wr_byte = r_wdata[31:24];
    endcase
    // read data trails the address by two counts because of the RAM latency
    w_rd_idx    = r_cnt[1:0] - 2'd2;
    w_assembled = r_rbuf | ({24'd0, mem_din} << {w_rd_idx, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_cnt      <= 3'd0;
      r_width    <= 3'd0;
      r_port_if  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rbuf     <= 32'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_rdy      <= 1'b0;
      r_if_rdy   <= 1'b0;
      r_data     <= 32'd0;
      r_if_data  <= 32'd0;
    end else if (rdy) begin
      case (r_state)
        c_st_idle: begin
          r_mem_wr <= 1'b0;
          if (w_take) begin
            r_port_if <= ~en_i;
            r_width   <= w_req_width;
            r_addr    <= w_req_addr;
            r_wdata   <= data_i;
            r_rbuf    <= 32'd0;
            if (!en_i || rw_i) begin
              r_state <= c_st_read;
              r_mem_a <= w_req_addr;
              r_cnt   <= 3'd1;
            end else begin
              r_state <= c_st_write;
              if (w_req_stall) begin
                r_cnt <= 3'd0;
              end else begin
                r_mem_a    <= w_req_addr;
                r_mem_dout <= data_i[7:0];
                r_mem_wr   <= 1'b1;
                r_cnt      <= 3'd1;
              end
            end
          end
        end

        c_st_read: begin
          if (r_cnt < r_width) begin
            r_mem_a <= w_byte_addr;
          end
          if (r_cnt >= 3'd2) begin
            r_rbuf <= w_assembled;
          end
          if (r_cnt == r_width + 3'd1) begin
            r_state <= c_st_done;
            r_cnt   <= 3'd0;
            if (r_port_if) begin
              r_if_data <= w_assembled;
              r_if_rdy  <= 1'b1;
            end else begin
              r_data <= w_assembled;
              r_rdy  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end

        c_st_write: begin
          if (r_cnt < r_width) begin
            // a full IO buffer holds the byte back until it drains
            if (w_byte_stall) begin
              r_mem_wr <= 1'b0;
            end else begin
              r_mem_a    <= w_byte_addr;
              r_mem_dout <= w_wr_byte;
              r_mem_wr   <= 1'b1;
              r_cnt      <= r_cnt + 3'd1;
            end
          end else begin
            r_mem_wr <= 1'b0;
            r_state  <= c_st_done;
            r_rdy    <= 1'b1;
            r_cnt    <= 3'd0;
          end
        end

        default: begin
          r_rdy    <= 1'b0;
          r_if_rdy <= 1'b0;
          r_mem_wr <= 1'b0;
          r_state  <= c_st_idle;
        end
      endcase
    end
  end

  assign mem_wr    = r_mem_wr & rdy;
  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  assign rdy_o     = r_rdy;
  assign if_rdy_o  = r_if_rdy;
  assign data_o    = r_data;
  assign if_data_o = r_if_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_ctrl
// Purpose : self-checking bench for ram_ctrl with a byte RAM and memory model
// Rev     : 1.0  initial release
// ============================================================================
module tb_ram_ctrl;

  logic        clk;
  logic        rst, rdy, en_i, rw_i, if_en_i, io_buffer_full;
  logic [2:0]  width_i;
  logic [31:0] addr_i, data_i, if_addr_i;
  logic        rdy_o, if_rdy_o, mem_wr;
  logic [31:0] data_o, if_data_o, mem_a;
  logic [7:0]  mem_din, mem_dout;

  ram_ctrl #(.IO_SEL(2'b11), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .en_i(en_i), .rw_i(rw_i), .width_i(width_i), .addr_i(addr_i), .data_i(data_i),
    .rdy_o(rdy_o), .data_o(data_o),
    .if_en_i(if_en_i), .if_addr_i(if_addr_i), .if_rdy_o(if_rdy_o), .if_data_o(if_data_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle read latency, frozen along with the rest of the system
  logic [7:0]  ram [0:4095];
  logic [39:0] wq [$];
  logic        ram_load, poke_en;
  logic [11:0] poke_a;
  logic [7:0]  poke_d;

  function automatic logic [7:0] init_byte(input logic [11:0] i);
    return i[7:0] ^ {i[11:8], i[11:8]} ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(12'(i));
    end
    if (poke_en) ram[poke_a] <= poke_d;
    if (rdy) mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wq.push_back({mem_a, mem_dout});
    end
  end

  // reference memory contents as the bench expects them
  logic [7:0]  model_mem [0:4095];
  logic [31:0] exp_d, exp_if;
  int          n_checks, n_pass;

  int          lat;
  logic [31:0] rd_val;
  bit          other_seen, long_pulse;
  logic [31:0] tr_a [0:15];
  logic        tr_wr [0:15];

  function automatic int eff_width(input logic [2:0] w);
    return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int nb);
    logic [31:0] v, t;
    v = 32'd0;
    for (int i = 0; i < nb; i++) begin
      t = a + i;
      v[8*i +: 8] = model_mem[t[11:0]];
    end
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int nb);
    logic [31:0] t;
    for (int i = 0; i < nb; i++) begin
      t = a + i;
      model_mem[t[11:0]] = d[8*i +: 8];
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
    model_mem[a] = d;
  endtask

  // One transaction: request held for a single edge, optional IO-full and rdy gaps
  task automatic run_op(input bit fetch, input bit rw, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int full_len, input int ra, input int rl);
    int k;
    bit got;
    en_i = ~fetch; if_en_i = fetch; rw_i = rw; width_i = w;
    addr_i = a; if_addr_i = a; data_i = d;
    io_buffer_full = (full_len > 0); rdy = 1'b1;
    other_seen = 0; long_pulse = 0; got = 0; lat = 0; rd_val = 32'd0;
    @(posedge clk); #1;
    k = 0; en_i = 1'b0; if_en_i = 1'b0;
    tr_a[0] = mem_a; tr_wr[0] = mem_wr;
    while (!got && k < 40) begin
      io_buffer_full = (k + 1 < full_len);
      rdy = !((k + 1) >= ra && (k + 1) < ra + rl);
      @(posedge clk); #1;
      k++;
      if (k < 16) begin tr_a[k] = mem_a; tr_wr[k] = mem_wr; end
      if (fetch ? rdy_o : if_rdy_o) other_seen = 1;
      if (fetch ? if_rdy_o : rdy_o) begin
        got = 1; lat = k; rd_val = fetch ? if_data_o : data_o;
      end
    end
    rdy = 1'b1; io_buffer_full = 1'b0;
    if (!got) $display("FAIL op_timeout: got no completion after %0d cycles, expected one", k);
    else begin
      @(posedge clk); #1;
      if (rdy_o || if_rdy_o) long_pulse = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem_a !== 32'd0) $display("FAIL reset_mem_a: got %h expected 0", mem_a); else n_pass++;
    n_checks++; if (mem_dout !== 8'd0) $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); else n_pass++;
    n_checks++; if (data_o !== 32'd0) $display("FAIL reset_data_o: got %h expected 0", data_o); else n_pass++;
    n_checks++; if (if_data_o !== 32'd0) $display("FAIL reset_if_data_o: got %h expected 0", if_data_o); else n_pass++;
    n_checks++; if ({rdy_o, if_rdy_o} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {rdy_o, if_rdy_o}); else n_pass++;
    rst = 1'b0;
    exp_d = 32'd0; exp_if = 32'd0;
  endtask

  task automatic test_read();
    int wbase;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    wbase = wq.size();
    run_op(1'b0, 1'b1, 3'd4, 32'h100, 32'd0, 0, 0, 0);
    n_checks++; if (lat !== 5) $display("FAIL read_latency: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (rd_val !== 32'h44332211) $display("FAIL read_data: got %h expected 44332211", rd_val); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tr_a[i] !== 32'h100 + i) $display("FAIL read_addr_seq[%0d]: got %h expected %h", i, tr_a[i], 32'h100 + i);
      else n_pass++;
    end
    n_checks++; if (long_pulse || other_seen) $display("FAIL read_pulse_shape: long=%0d other=%0d expected 0 0", long_pulse, other_seen); else n_pass++;
    n_checks++; if (wq.size() != wbase) $display("FAIL read_no_write: got %0d writes expected 0", wq.size() - wbase); else n_pass++;
    exp_d = 32'h44332211;
  endtask

  task automatic test_write();
    int wbase;
    wbase = wq.size();
    run_op(1'b0, 1'b0, 3'd2, 32'h200, 32'h0000ABCD, 0, 0, 0);
    model_write(32'h200, 32'h0000ABCD, 2);
    n_checks++; if (lat !== 2) $display("FAIL write_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (wq.size() - wbase != 2) $display("FAIL write_count: got %0d expected 2", wq.size() - wbase); else n_pass++;
    if (wq.size() - wbase == 2) begin
      n_checks++; if (wq[wbase] !== {32'h200, 8'hCD}) $display("FAIL write_byte0: got %h expected %h", wq[wbase], {32'h200, 8'hCD}); else n_pass++;
      n_checks++; if (wq[wbase+1] !== {32'h201, 8'hAB}) $display("FAIL write_byte1: got %h expected %h", wq[wbase+1], {32'h201, 8'hAB}); else n_pass++;
    end
    n_checks++; if (long_pulse) $display("FAIL write_pulse_len: got long pulse expected single cycle"); else n_pass++;
    n_checks++; if (data_o !== exp_d) $display("FAIL write_keeps_data_o: got %h expected %h", data_o, exp_d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    run_op(1'b0, 1'b0, 3'd4, 32'h700, d, 0, 0, 0);
    model_write(32'h700, d, 4);
    n_checks++; if (lat !== 4) $display("FAIL b2b_write_latency: got %0d expected 4", lat); else n_pass++;
    run_op(1'b0, 1'b1, 3'd4, 32'h700, 32'd0, 0, 0, 0);
    n_checks++; if (rd_val !== d) $display("FAIL b2b_readback: got %h expected %h", rd_val, d); else n_pass++;
    exp_d = d;
  endtask

  task automatic test_arbitration();
    int k, d_at, f_at, n_d;
    bit overlap;
    logic [31:0] dval, fval;
    en_i = 1'b1; rw_i = 1'b1; width_i = 3'd4; addr_i = 32'h400;
    if_en_i = 1'b1; if_addr_i = 32'h500; rdy = 1'b1; io_buffer_full = 1'b0;
    @(posedge clk); #1;
    en_i = 1'b0;
    k = 0; d_at = -1; f_at = -1; n_d = 0; overlap = 0; dval = 32'd0; fval = 32'd0;
    while (f_at < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (rdy_o && if_rdy_o) overlap = 1;
      if (rdy_o) begin
        n_d++;
        if (d_at < 0) begin d_at = k; dval = data_o; end
      end
      if (if_rdy_o) begin f_at = k; fval = if_data_o; if_en_i = 1'b0; end
    end
    if_en_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (d_at !== 5) $display("FAIL arb_data_first: got cycle %0d expected 5", d_at); else n_pass++;
    n_checks++; if (f_at !== 12) $display("FAIL arb_fetch_after: got cycle %0d expected 12", f_at); else n_pass++;
    n_checks++; if (overlap || n_d != 1) $display("FAIL arb_pulses: overlap=%0d data_pulses=%0d expected 0 1", overlap, n_d); else n_pass++;
    n_checks++; if (dval !== model_read(32'h400, 4)) $display("FAIL arb_data_val: got %h expected %h", dval, model_read(32'h400, 4)); else n_pass++;
    n_checks++; if (fval !== model_read(32'h500, 4)) $display("FAIL arb_fetch_val: got %h expected %h", fval, model_read(32'h500, 4)); else n_pass++;
    n_checks++; if (if_rdy_o !== 1'b0) $display("FAIL arb_fetch_pulse_len: got %b expected 0", if_rdy_o); else n_pass++;
    exp_d = model_read(32'h400, 4); exp_if = model_read(32'h500, 4);
  endtask

  task automatic test_io_stall();
    int wbase;
    wbase = wq.size();
    run_op(1'b0, 1'b0, 3'd1, 32'h0003_0000, 32'h0000005A, 3, 0, 0);
    model_write(32'h0003_0000, 32'h5A, 1);
    n_checks++; if (lat !== 4) $display("FAIL io_stall_latency: got %0d expected 4", lat); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (tr_wr[i] !== 1'b0) $display("FAIL io_stall_wr[%0d]: got %b expected 0", i, tr_wr[i]); else n_pass++;
    end
    n_checks++; if (tr_wr[3] !== 1'b1) $display("FAIL io_issue_after_drain: got %b expected 1", tr_wr[3]); else n_pass++;
    n_checks++; if (wq.size() - wbase != 1) $display("FAIL io_write_count: got %0d expected 1", wq.size() - wbase); else n_pass++;
    if (wq.size() - wbase == 1) begin
      n_checks++; if (wq[wbase] !== {32'h0003_0000, 8'h5A}) $display("FAIL io_write_byte: got %h expected %h", wq[wbase], {32'h0003_0000, 8'h5A}); else n_pass++;
    end
    run_op(1'b0, 1'b1, 3'd1, 32'h0003_0000, 32'd0, 3, 0, 0);
    n_checks++; if (lat !== 2) $display("FAIL io_read_unstalled: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (rd_val !== 32'h5A) $display("FAIL io_read_data: got %h expected 0000005a", rd_val); else n_pass++;
    exp_d = 32'h5A;
    run_op(1'b0, 1'b0, 3'd1, 32'h0002_0040, 32'h00000077, 3, 0, 0);
    model_write(32'h0002_0040, 32'h77, 1);
    n_checks++; if (lat !== 1) $display("FAIL nonio_write_unstalled: got %0d expected 1", lat); else n_pass++;
  endtask

  task automatic test_rdy_freeze();
    int wbase;
    poke(12'h305, 8'h9F);
    run_op(1'b0, 1'b1, 3'd1, 32'h305, 32'd0, 0, 1, 2);
    n_checks++; if (lat !== 4) $display("FAIL freeze_read_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (rd_val !== 32'h0000009F) $display("FAIL freeze_read_data: got %h expected 0000009f", rd_val); else n_pass++;
    n_checks++; if (data_o !== 32'h0000009F) $display("FAIL data_o_hold: got %h expected 0000009f", data_o); else n_pass++;
    exp_d = 32'h9F;
    wbase = wq.size();
    run_op(1'b0, 1'b0, 3'd2, 32'h310, 32'h00003C4B, 0, 1, 2);
    model_write(32'h310, 32'h3C4B, 2);
    n_checks++; if (lat !== 4) $display("FAIL freeze_write_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (wq.size() - wbase != 2) $display("FAIL freeze_write_count: got %0d expected 2", wq.size() - wbase); else n_pass++;
  endtask

  task automatic test_wrap();
    int wbase;
    logic [31:0] ta;
    wbase = wq.size();
    run_op(1'b0, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h1357_9BDF, 0, 0, 0);
    model_write(32'hFFFF_FFFE, 32'h1357_9BDF, 4);
    n_checks++; if (wq.size() - wbase != 4) $display("FAIL wrap_count: got %0d expected 4", wq.size() - wbase); else n_pass++;
    if (wq.size() - wbase == 4) begin
      for (int i = 0; i < 4; i++) begin
        ta = 32'hFFFF_FFFE + i;
        n_checks++;
        if (wq[wbase+i][39:8] !== ta) $display("FAIL wrap_addr[%0d]: got %h expected %h", i, wq[wbase+i][39:8], ta);
        else n_pass++;
      end
    end
    run_op(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFE, 32'd0, 0, 0, 0);
    n_checks++; if (rd_val !== 32'h1357_9BDF) $display("FAIL wrap_readback: got %h expected 13579bdf", rd_val); else n_pass++;
    exp_d = 32'h1357_9BDF;
  endtask

  task automatic test_reset_mid();
    int wbase, n_pulse;
    wbase = wq.size();
    en_i = 1'b1; rw_i = 1'b0; width_i = 3'd4; addr_i = 32'h600; data_i = 32'hDEAD_BEEF;
    if_en_i = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    @(posedge clk); #1;
    en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_mid_mem_wr: got %b expected 0", mem_wr); else n_pass++;
    rst = 1'b0;
    exp_d = 32'd0; exp_if = 32'd0;
    n_pulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rdy_o || if_rdy_o) n_pulse++;
    end
    n_checks++; if (n_pulse != 0) $display("FAIL rst_mid_no_pulse: got %0d pulses expected 0", n_pulse); else n_pass++;
    n_checks++; if (wq.size() - wbase != 2) $display("FAIL rst_mid_writes: got %0d expected 2", wq.size() - wbase); else n_pass++;
    n_checks++; if (data_o !== 32'd0) $display("FAIL rst_mid_data_o: got %h expected 0", data_o); else n_pass++;
    model_write(32'h600, 32'h0000BEEF, 2);
    run_op(1'b0, 1'b1, 3'd4, 32'h600, 32'd0, 0, 0, 0);
    n_checks++; if (lat !== 5) $display("FAIL rst_mid_fresh_latency: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (rd_val !== model_read(32'h600, 4)) $display("FAIL rst_mid_fresh_data: got %h expected %h", rd_val, model_read(32'h600, 4)); else n_pass++;
    exp_d = model_read(32'h600, 4);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit fetch, rw, io;
      logic [2:0] w;
      int nb, fl, ra, rl, exp_lat, wbase;
      logic [31:0] a, d, r, ev, ta;
      fetch = ($urandom_range(0, 3) == 0);
      rw = fetch ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: w = 3'd1;
        1: w = 3'd2;
        2: w = 3'd4;
        3: w = 3'd3;
        4: w = 3'd0;
        default: w = 3'd7;
      endcase
      nb = fetch ? 4 : eff_width(w);
      io = ($urandom_range(0, 2) == 0);
      r = $urandom;
      a = {r[31:18], io ? 2'b11 : 2'b00, 4'h0, r[11:0]};
      d = $urandom;
      fl = $urandom_range(0, 3);
      if (fl == 0 && $urandom_range(0, 1) == 1) begin
        ra = $urandom_range(1, rw ? nb + 1 : nb);
        rl = $urandom_range(1, 3);
      end else begin
        ra = 0; rl = 0;
      end
      exp_lat = (rw ? nb + 1 : nb) + rl + ((!rw && io) ? fl : 0);
      wbase = wq.size();
      run_op(fetch, rw, w, a, d, fl, ra, rl);
      n_checks++; if (lat !== exp_lat) $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat); else n_pass++;
      if (rw) begin
        ev = model_read(a, nb);
        n_checks++; if (rd_val !== ev) $display("FAIL rand%0d_rdata: got %h expected %h", it, rd_val, ev); else n_pass++;
        if (fetch) exp_if = ev; else exp_d = ev;
      end else begin
        n_checks++; if (wq.size() - wbase != nb) $display("FAIL rand%0d_wcount: got %0d expected %0d", it, wq.size() - wbase, nb); else n_pass++;
        if (wq.size() - wbase == nb) begin
          for (int i = 0; i < nb; i++) begin
            ta = a + i;
            n_checks++;
            if (wq[wbase+i] !== {ta, d[8*i +: 8]}) $display("FAIL rand%0d_wbyte%0d: got %h expected %h", it, i, wq[wbase+i], {ta, d[8*i +: 8]});
            else n_pass++;
          end
        end
        model_write(a, d, nb);
      end
      n_checks++;
      if (data_o !== exp_d || if_data_o !== exp_if)
        $display("FAIL rand%0d_outputs: got %h/%h expected %h/%h", it, data_o, if_data_o, exp_d, exp_if);
      else n_pass++;
      n_checks++;
      if (other_seen || long_pulse) $display("FAIL rand%0d_pulse: wrong_port=%0d long=%0d expected 0 0", it, other_seen, long_pulse);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; rdy = 1'b1; en_i = 1'b0; rw_i = 1'b0; width_i = 3'd0;
    addr_i = 32'd0; data_i = 32'd0; if_en_i = 1'b0; if_addr_i = 32'd0;
    io_buffer_full = 1'b0; poke_en = 1'b0; poke_a = 12'd0; poke_d = 8'd0;
    exp_d = 32'd0; exp_if = 32'd0;
    for (int i = 0; i < 4096; i++) model_mem[i] = init_byte(12'(i));
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_arbitration();
    test_io_stall();
    test_rdy_freeze();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
